// File: rtl/sketch_pkg.sv
// Shared constants for the Etch-A-Sketch cursor controller: default geometry,
// FSM state encoding and write-data polarity.
package sketch_pkg;

    localparam int X_MAX_DEFAULT = 127;
    localparam int Y_MAX_DEFAULT = 95;
    localparam int X_W_DEFAULT   = 7;
    localparam int Y_W_DEFAULT   = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic WR_INK   = 1'b1;
    localparam logic WR_ERASE = 1'b0;

    typedef struct packed {
        logic inc;
        logic dec;
    } axis_step_t;

endpackage

// File: rtl/sketch_clear_sweeper.sv
// Raster address generator for the shake-clear: x runs 0..X_MAX inside
// y 0..Y_MAX, advancing one pixel per accepted erase write.
module sketch_clear_sweeper
    import sketch_pkg::*;
#(
    parameter int X_MAX = X_MAX_DEFAULT,
    parameter int Y_MAX = Y_MAX_DEFAULT,
    parameter int X_W   = X_W_DEFAULT,
    parameter int Y_W   = Y_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           adv,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           x_end;
    logic           y_end;

    assign x_end = (x_q == X_W'(X_MAX));
    assign y_end = (y_q == Y_W'(Y_MAX));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (start) begin
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = x_end && y_end;

endmodule

// File: rtl/sketch_cursor_ctrl.sv
// Etch-A-Sketch cursor controller: turns axis step pulses into a saturating
// cursor, issues ink writes when the pen is down, and sequences the clear sweep.
module sketch_cursor_ctrl
    import sketch_pkg::*;
#(
    parameter int X_MAX = X_MAX_DEFAULT,
    parameter int Y_MAX = Y_MAX_DEFAULT,
    parameter int X_W   = X_W_DEFAULT,
    parameter int Y_W   = Y_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           x_inc,
    input  logic           x_dec,
    input  logic           y_inc,
    input  logic           y_dec,
    input  logic           pen_down,
    input  logic           clear_req,
    output logic           wr_valid,
    input  logic           wr_ready,
    output logic [X_W-1:0] wr_x,
    output logic [Y_W-1:0] wr_y,
    output logic           wr_data,
    output logic [X_W-1:0] cur_x,
    output logic [Y_W-1:0] cur_y,
    output logic           busy
);

    logic [1:0]     state_q, state_d;
    logic [X_W-1:0] cur_x_q, cur_x_d;
    logic [Y_W-1:0] cur_y_q, cur_y_d;
    axis_step_t     xp_q, xp_d;
    axis_step_t     yp_q, yp_d;
    logic           clr_pend_q, clr_pend_d;
    logic           wr_valid_q, wr_valid_d;
    logic [X_W-1:0] wr_x_q, wr_x_d;
    logic [Y_W-1:0] wr_y_q, wr_y_d;
    logic           wr_data_q, wr_data_d;

    logic           step_xi, step_xd, step_yi, step_yd;
    logic           any_step;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic           moved;
    logic           handshake;
    logic           clear_now;

    logic           sw_start;
    logic           sw_adv;
    logic [X_W-1:0] sw_x;
    logic [Y_W-1:0] sw_y;
    logic           sw_last;

    sketch_clear_sweeper #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_sweeper (
        .clk   (clk),
        .rst   (rst),
        .start (sw_start),
        .adv   (sw_adv),
        .x     (sw_x),
        .y     (sw_y),
        .last  (sw_last)
    );

    // A pulse arriving on the consuming edge counts as if already latched.
    assign step_xi   = xp_q.inc | x_inc;
    assign step_xd   = xp_q.dec | x_dec;
    assign step_yi   = yp_q.inc | y_inc;
    assign step_yd   = yp_q.dec | y_dec;
    assign any_step  = step_xi | step_xd | step_yi | step_yd;
    assign handshake = wr_valid_q & wr_ready;
    assign clear_now = clr_pend_q | clear_req;

    always_comb begin
        nx = cur_x_q;
        if (step_xi && !step_xd && (cur_x_q != X_W'(X_MAX))) begin
            nx = cur_x_q + 1'b1;
        end else if (step_xd && !step_xi && (cur_x_q != '0)) begin
            nx = cur_x_q - 1'b1;
        end
        ny = cur_y_q;
        if (step_yi && !step_yd && (cur_y_q != Y_W'(Y_MAX))) begin
            ny = cur_y_q + 1'b1;
        end else if (step_yd && !step_yi && (cur_y_q != '0)) begin
            ny = cur_y_q - 1'b1;
        end
        moved = (nx != cur_x_q) || (ny != cur_y_q);
    end

    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        xp_d.inc   = step_xi;
        xp_d.dec   = step_xd;
        yp_d.inc   = step_yi;
        yp_d.dec   = step_yd;
        clr_pend_d = clr_pend_q | (clear_req && (state_q != ST_CLEAR));
        wr_valid_d = wr_valid_q;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_data_d  = wr_data_q;
        sw_start   = 1'b0;
        sw_adv     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear_now) begin
                    state_d    = ST_CLEAR;
                    clr_pend_d = 1'b0;
                    sw_start   = 1'b1;
                    wr_valid_d = 1'b1;
                    wr_x_d     = '0;
                    wr_y_d     = '0;
                    wr_data_d  = WR_ERASE;
                end else if (any_step) begin
                    cur_x_d = nx;
                    cur_y_d = ny;
                    xp_d    = '0;
                    yp_d    = '0;
                    if (pen_down && moved) begin
                        state_d    = ST_WRITE;
                        wr_valid_d = 1'b1;
                        wr_x_d     = nx;
                        wr_y_d     = ny;
                        wr_data_d  = WR_INK;
                    end
                end
            end

            ST_WRITE: begin
                if (handshake) begin
                    if (clear_now) begin
                        state_d    = ST_CLEAR;
                        clr_pend_d = 1'b0;
                        sw_start   = 1'b1;
                        wr_x_d     = '0;
                        wr_y_d     = '0;
                        wr_data_d  = WR_ERASE;
                    end else begin
                        state_d    = ST_IDLE;
                        wr_valid_d = 1'b0;
                    end
                end
            end

            ST_CLEAR: begin
                if (handshake) begin
                    sw_adv = 1'b1;
                    if (sw_last) begin
                        state_d    = ST_IDLE;
                        wr_valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                wr_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_x_q    <= X_W'(X_MAX >> 1);
            cur_y_q    <= Y_W'(Y_MAX >> 1);
            xp_q       <= '0;
            yp_q       <= '0;
            clr_pend_q <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_data_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            xp_q       <= xp_d;
            yp_q       <= yp_d;
            clr_pend_q <= clr_pend_d;
            wr_valid_q <= wr_valid_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // During a sweep the address comes straight from the raster counter.
    assign wr_x     = (state_q == ST_CLEAR) ? sw_x : wr_x_q;
    assign wr_y     = (state_q == ST_CLEAR) ? sw_y : wr_y_q;
    assign wr_valid = wr_valid_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q == ST_CLEAR);
    assign cur_x    = cur_x_q;
    assign cur_y    = cur_y_q;

endmodule

// File: tb/tb_sketch_cursor_ctrl.sv
// Bench for sketch_cursor_ctrl on a 4x3 screen: scenario tasks drive stimulus,
// a negedge monitor pops expected pixel writes from a scoreboard queue.
module tb_sketch_cursor_ctrl;

    localparam int XM = 3;
    localparam int YM = 2;
    localparam int XW = 2;
    localparam int YW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          x_inc = 1'b0, x_dec = 1'b0, y_inc = 1'b0, y_dec = 1'b0;
    logic          pen_down = 1'b0;
    logic          clear_req = 1'b0;
    logic          wr_ready = 1'b0;
    logic          wr_valid;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic          wr_data;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          busy;

    int checks  = 0;
    int passes  = 0;
    int acc_cnt = 0;

    logic [XW+YW:0] exp_q[$];

    sketch_cursor_ctrl #(
        .X_MAX (XM),
        .Y_MAX (YM),
        .X_W   (XW),
        .Y_W   (YW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x_inc     (x_inc),
        .x_dec     (x_dec),
        .y_inc     (y_inc),
        .y_dec     (y_dec),
        .pen_down  (pen_down),
        .clear_req (clear_req),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Inputs are stable across negedge and the following posedge, so a
    // valid&ready seen here is the handshake that edge commits.
    always @(negedge clk) begin
        logic [XW+YW:0] e;
        if (!rst && wr_valid && wr_ready) begin
            acc_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got (%0d,%0d,d=%0b) required no write",
                         wr_x, wr_y, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_x, wr_y, wr_data} !== e)
                    $display("FAIL write_value: got (%0d,%0d,d=%0b) required (%0d,%0d,d=%0b)",
                             wr_x, wr_y, wr_data, e[XW+YW:YW+1], e[YW:1], e[0]);
                else
                    passes++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void push(input int x, input int y, input logic d);
        logic [XW-1:0] xx;
        logic [YW-1:0] yy;
        xx = XW'(x);
        yy = YW'(y);
        exp_q.push_back({xx, yy, d});
    endfunction

    function automatic void push_raster();
        for (int y = 0; y <= YM; y++)
            for (int x = 0; x <= XM; x++)
                push(x, y, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic xi, input logic xd, input logic yi,
                         input logic yd, input logic cr);
        x_inc = xi; x_dec = xd; y_inc = yi; y_dec = yd; clear_req = cr;
        tick();
        x_inc = 0; x_dec = 0; y_inc = 0; y_dec = 0; clear_req = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    endtask

    task automatic apply_reset();
        x_inc = 0; x_dec = 0; y_inc = 0; y_dec = 0; clear_req = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if (cur_x !== 2'd1 || cur_y !== 2'd1 || wr_valid !== 1'b0 || busy !== 1'b0 ||
            wr_x !== 2'd0 || wr_y !== 2'd0 || wr_data !== 1'b0)
            $display("FAIL reset_state: got cur=(%0d,%0d) v=%0b busy=%0b wr=(%0d,%0d,%0b) required cur=(1,1) v=0 busy=0 wr=(0,0,0)",
                     cur_x, cur_y, wr_valid, busy, wr_x, wr_y, wr_data);
        else passes++;
        tick();
        tick();
        rst = 1'b0;
        idle(2);
        checks++;
        if (cur_x !== 2'd1 || cur_y !== 2'd1 || wr_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_release: got cur=(%0d,%0d) v=%0b busy=%0b required cur=(1,1) v=0 busy=0",
                     cur_x, cur_y, wr_valid, busy);
        else passes++;
    endtask

    task automatic test_single_step();
        pen_down = 1'b1;
        wr_ready = 1'b1;
        push(2, 1, 1'b1);
        pulse(1, 0, 0, 0, 0);
        checks++;
        if (cur_x !== 2'd2 || wr_valid !== 1'b1)
            $display("FAIL step_cur_x: got cur_x=%0d v=%0b required cur_x=2 v=1", cur_x, wr_valid);
        else passes++;
        tick();
        checks++;
        if (wr_valid !== 1'b0)
            $display("FAIL step_valid_drop: got v=%0b required 0", wr_valid);
        else passes++;
        drain();
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL step_write_count: got %0d outstanding required 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_saturation();
        int inc_exp[3] = '{2, 3, 3};
        int dec_exp[5] = '{2, 1, 0, 0, 0};
        int prev;
        apply_reset();
        pen_down = 1'b1;
        wr_ready = 1'b1;
        prev = 1;
        for (int i = 0; i < 3; i++) begin
            if (inc_exp[i] != prev) push(inc_exp[i], 1, 1'b1);
            pulse(1, 0, 0, 0, 0);
            checks++;
            if (cur_x !== XW'(inc_exp[i]))
                $display("FAIL sat_inc_%0d: got cur_x=%0d required %0d", i, cur_x, inc_exp[i]);
            else passes++;
            prev = inc_exp[i];
            idle(20);
        end
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL sat_inc_writes: got %0d outstanding required 0", exp_q.size());
        else passes++;
        for (int i = 0; i < 5; i++) begin
            if (dec_exp[i] != prev) push(dec_exp[i], 1, 1'b1);
            pulse(0, 1, 0, 0, 0);
            checks++;
            if (cur_x !== XW'(dec_exp[i]))
                $display("FAIL sat_dec_%0d: got cur_x=%0d required %0d", i, cur_x, dec_exp[i]);
            else passes++;
            prev = dec_exp[i];
            idle(20);
        end
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL sat_dec_writes: got %0d outstanding required 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_cancel_and_pen_up();
        pulse(1, 1, 0, 0, 0);
        checks++;
        if (cur_x !== 2'd0 || cur_y !== 2'd1)
            $display("FAIL cancel_x: got cur=(%0d,%0d) required (0,1)", cur_x, cur_y);
        else passes++;
        pen_down = 1'b0;
        pulse(0, 0, 1, 0, 0);
        checks++;
        if (cur_y !== 2'd2)
            $display("FAIL pen_up_y: got cur_y=%0d required 2", cur_y);
        else passes++;
        idle(5);
        checks++;
        if (wr_valid !== 1'b0)
            $display("FAIL pen_up_no_write: got v=%0b required 0", wr_valid);
        else passes++;
    endtask

    task automatic test_backpressure();
        pen_down = 1'b1;
        wr_ready = 1'b0;
        push(1, 2, 1'b1);
        pulse(1, 0, 0, 0, 0);
        checks++;
        if (cur_x !== 2'd1 || wr_valid !== 1'b1)
            $display("FAIL bp_start: got cur_x=%0d v=%0b required cur_x=1 v=1", cur_x, wr_valid);
        else passes++;
        for (int i = 0; i < 7; i++) begin
            y_dec = (i == 3);
            if (i == 3) push(1, 1, 1'b1);
            tick();
            checks++;
            if (wr_valid !== 1'b1 || wr_x !== 2'd1 || wr_y !== 2'd2 || wr_data !== 1'b1 || cur_y !== 2'd2)
                $display("FAIL bp_hold_%0d: got v=%0b wr=(%0d,%0d,%0b) cur_y=%0d required v=1 wr=(1,2,1) cur_y=2",
                         i, wr_valid, wr_x, wr_y, wr_data, cur_y);
            else passes++;
        end
        y_dec = 1'b0;
        wr_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (cur_y !== 2'd1 || wr_valid !== 1'b1 || wr_y !== 2'd1)
            $display("FAIL bp_pending_step: got cur_y=%0d v=%0b wr_y=%0d required cur_y=1 v=1 wr_y=1",
                     cur_y, wr_valid, wr_y);
        else passes++;
        drain();
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL bp_writes: got %0d outstanding required 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_clear();
        bit done;
        push_raster();
        wr_ready = 1'b1;
        pulse(0, 0, 0, 0, 1);
        checks++;
        if (busy !== 1'b1 || wr_valid !== 1'b1 || wr_x !== 2'd0 || wr_y !== 2'd0 || wr_data !== 1'b0)
            $display("FAIL clear_start: got busy=%0b v=%0b wr=(%0d,%0d,%0b) required busy=1 v=1 wr=(0,0,0)",
                     busy, wr_valid, wr_x, wr_y, wr_data);
        else passes++;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            wr_ready  = (i % 2 == 0);
            clear_req = (i == 6);
            tick();
            if (busy !== 1'b1) done = 1'b1;
        end
        clear_req = 1'b0;
        checks++;
        if (busy !== 1'b0 || wr_valid !== 1'b0)
            $display("FAIL clear_end: got busy=%0b v=%0b required busy=0 v=0", busy, wr_valid);
        else passes++;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL clear_count: got %0d writes missing required 0", exp_q.size());
        else passes++;
        checks++;
        if (cur_x !== 2'd1 || cur_y !== 2'd1)
            $display("FAIL clear_cursor: got (%0d,%0d) required (1,1)", cur_x, cur_y);
        else passes++;
        wr_ready = 1'b1;
        idle(10);
        checks++;
        if (busy !== 1'b0 || wr_valid !== 1'b0)
            $display("FAIL clear_no_restart: got busy=%0b v=%0b required busy=0 v=0", busy, wr_valid);
        else passes++;
    endtask

    task automatic test_reset_mid_clear();
        pen_down = 1'b0;
        pulse(1, 0, 0, 0, 0);
        checks++;
        if (cur_x !== 2'd2)
            $display("FAIL rmc_premove: got cur_x=%0d required 2", cur_x);
        else passes++;
        wr_ready = 1'b1;
        push_raster();
        acc_cnt = 0;
        pulse(0, 0, 0, 0, 1);
        for (int i = 0; i < 50 && acc_cnt < 5; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (acc_cnt != 5)
            $display("FAIL rmc_accepts: got %0d required 5", acc_cnt);
        else passes++;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || cur_x !== 2'd1 || cur_y !== 2'd1 ||
            wr_x !== 2'd0 || wr_y !== 2'd0 || wr_data !== 1'b0)
            $display("FAIL rmc_async: got v=%0b busy=%0b cur=(%0d,%0d) wr=(%0d,%0d,%0b) required v=0 busy=0 cur=(1,1) wr=(0,0,0)",
                     wr_valid, busy, cur_x, cur_y, wr_x, wr_y, wr_data);
        else passes++;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        idle(10);
        checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || cur_x !== 2'd1 || cur_y !== 2'd1)
            $display("FAIL rmc_after: got v=%0b busy=%0b cur=(%0d,%0d) required v=0 busy=0 cur=(1,1)",
                     wr_valid, busy, cur_x, cur_y);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_saturation();
        test_cancel_and_pen_up();
        test_backpressure();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
